// File: rtl/rr_stream_mux_pkg.sv
// rtl/rr_stream_mux_pkg.sv - shared defaults and wrap-at-N index increment
package rr_stream_mux_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;

  // Channel counts need not be powers of two, so the index wraps at n explicitly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at i_ptr
// Produces a one-hot grant plus its index; o_grant_valid is 0 when nothing requests.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [SELW-1:0] o_grant_idx,
  output logic            o_grant_valid
);

  int unsigned       v_cand;
  logic [SELW-1:0]   v_sel;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    v_cand        = 0;
    v_sel         = '0;
    for (int k = 0; k < N; k++) begin
      v_cand = 32'(i_ptr) + 32'(k);
      if (v_cand >= N) v_cand = v_cand - N;
      v_sel = SELW'(v_cand);
      if (!o_grant_valid && i_req[v_sel]) begin
        o_grant_valid  = 1'b1;
        o_grant[v_sel] = 1'b1;
        o_grant_idx    = v_sel;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-to-1 round-robin stream mux with a 1-entry output register
// Define RR_STREAM_MUX_LOCK_EN to hold the grant on one channel until its last beat.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;

  logic             w_can_load;
  logic             w_accept;
  logic             w_grant_valid;
  logic [N-1:0]     w_req;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_grant_idx;
  logic [SELW-1:0]  w_arb_ptr;
  logic [SELW-1:0]  w_ptr_next;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic            r_locked;
  logic [SELW-1:0] r_lock_ch;

  // While locked only the owning channel may request, so a gap on it stalls the mux.
  always_comb begin
    w_req     = in_valid;
    w_arb_ptr = r_ptr;
    if (r_locked) begin
      w_req     = in_valid & (N'(1) << r_lock_ch);
      w_arb_ptr = r_lock_ch;
    end
  end
`else
  assign w_req     = in_valid;
  assign w_arb_ptr = r_ptr;
`endif

  rr_arbiter #(.N(N)) u_arbiter (
    .i_req         (w_req),
    .i_ptr         (w_arb_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign w_can_load = !r_out_valid || out_ready;
  assign w_accept   = w_grant_valid && w_can_load && !reset;
  assign in_ready   = w_accept ? w_grant : '0;
  assign w_ptr_next = SELW'(wrap_inc(32'(w_grant_idx), N));

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
    w_sel_last = |(in_last & w_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
      r_locked    <= 1'b0;
      r_lock_ch   <= '0;
`endif
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_sel   <= w_grant_idx;
`ifdef RR_STREAM_MUX_LOCK_EN
      if (w_sel_last) begin
        r_locked <= 1'b0;
        r_ptr    <= w_ptr_next;
      end else begin
        r_locked  <= 1'b1;
        r_lock_ch <= w_grant_idx;
      end
`else
      r_ptr       <= w_ptr_next;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - directed scoreboard bench for rr_stream_mux (N=4 and N=3)
// The packet-lock scenario runs only when RR_STREAM_MUX_LOCK_EN is defined.
module tb_rr_stream_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [2:0]   in_valid3;
  logic [23:0]  in_data3;
  logic [2:0]   in_last3;
  logic [2:0]   in_ready3;
  logic         out_valid3;
  logic [7:0]   out_data3;
  logic         out_last3;
  logic [1:0]   out_sel3;
  logic         out_ready3;

  int vectors     = 0;
  int miscompares = 0;

  logic [34:0] q4[$];
  logic [10:0] q3[$];
  logic [3:0]  seen_ready;
  logic [2:0]  seen_ready3;

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_stream_mux #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3),
    .out_sel(out_sel3), .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [31:0] d, input logic l);
    in_data[i*32 +: 32] = d;
    in_last[i]          = l;
  endtask

  task automatic push4(input logic [1:0] s, input logic [31:0] d, input logic l);
    q4.push_back({l, s, d});
  endtask

  // Output transfers are observed at the falling edge, one half-cycle before they complete.
  task automatic tick();
    logic [34:0] e4;
    logic [10:0] e3;
    @(negedge clk);
    seen_ready  = in_ready;
    seen_ready3 = in_ready3;
    if (out_valid && out_ready) begin
      if (q4.size() == 0) check("sb4_unexpected_beat", 64'(out_sel), 64'h0bad);
      else begin
        e4 = q4.pop_front();
        check("sb4_sel",  64'(out_sel),  64'(e4[33:32]));
        check("sb4_data", 64'(out_data), 64'(e4[31:0]));
        check("sb4_last", 64'(out_last), 64'(e4[34]));
      end
    end
    if (out_valid3 && out_ready3) begin
      if (q3.size() == 0) check("sb3_unexpected_beat", 64'(out_sel3), 64'h0bad);
      else begin
        e3 = q3.pop_front();
        check("sb3_sel",  64'(out_sel3),  64'(e3[9:8]));
        check("sb3_data", 64'(out_data3), 64'(e3[7:0]));
        check("sb3_last", 64'(out_last3), 64'(e3[10]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    in_valid  = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; in_valid = 4'b1111; in_data = '0; in_last = '0;
    in_valid3 = '0; in_data3 = '0; in_last3 = '0; out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i), 1'b0);

    // reset state, with requests present
    tick();
    check("rst_in_ready", 64'(seen_ready), 64'h0);
    tick();
    check("rst_in_ready_2", 64'(seen_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_out_last",  64'(out_last),  64'h0);
    check("rst_out_sel",   64'(out_sel),   64'h0);

    // all four valid, out_ready high: 0,1,2,3,0
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push4(2'(i), 32'hA0 + 32'(i), 1'b0);
    push4(2'd0, 32'hA0, 1'b0);
    tick();
    check("rr_first_ready", 64'(seen_ready), 64'h1);
    check("rr_latency_valid", 64'(out_valid), 64'h1);
    check("rr_latency_sel", 64'(out_sel), 64'h0);
    for (int i = 0; i < 4; i++) tick();
    in_valid = '0;
    tick();
    tick();
    check("rr_idle_valid", 64'(out_valid), 64'h0);

    // sparse requests 1010 from ptr=0
    do_reset();
    out_ready = 1'b1;
    set_ch(0, 32'h00, 1'b0); set_ch(1, 32'h11, 1'b1);
    set_ch(2, 32'h22, 1'b0); set_ch(3, 32'h33, 1'b1);
    in_valid = 4'b1010;
    push4(2'd1, 32'h11, 1'b1); push4(2'd3, 32'h33, 1'b1); push4(2'd1, 32'h11, 1'b1);
    tick();
    check("sparse_ready_1", 64'(seen_ready), 64'h2);
    tick();
    check("sparse_ready_2", 64'(seen_ready), 64'h8);
    tick();
    in_valid = '0;
    tick();
    tick();

    // backpressure hold
    out_ready = 1'b0;
    set_ch(2, 32'hDEADBEEF, 1'b1);
    in_valid = 4'b0100;
    push4(2'd2, 32'hDEADBEEF, 1'b1);
    tick();
    set_ch(2, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_data",  64'(out_data),   64'hDEADBEEF);
      check("hold_ready", 64'(seen_ready), 64'h0);
    end
    out_ready = 1'b1;
    push4(2'd2, 32'hCAFEF00D, 1'b0);
    tick();
    check("release_ready", 64'(seen_ready), 64'h4);
    in_valid = '0;
    tick();
    tick();

    // N=3 wraps at 3
    for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'h30 + 8'(i);
    in_valid3 = 3'b111;
    for (int i = 0; i < 3; i++) q3.push_back({1'b0, 2'(i), 8'h30 + 8'(i)});
    q3.push_back({1'b0, 2'd0, 8'h30});
    for (int i = 0; i < 4; i++) tick();
    in_valid3 = '0;
    tick();
    tick();

`ifdef RR_STREAM_MUX_LOCK_EN
    // ch2 3-beat packet holds the grant while ch0 waits
    do_reset();
    out_ready = 1'b1;
    set_ch(2, 32'h201, 1'b0);
    in_valid = 4'b0100;
    push4(2'd2, 32'h201, 1'b0); push4(2'd2, 32'h202, 1'b0);
    push4(2'd2, 32'h203, 1'b1); push4(2'd0, 32'h0F0, 1'b1);
    tick();
    set_ch(2, 32'h202, 1'b0); set_ch(0, 32'h0F0, 1'b1);
    in_valid = 4'b0101;
    tick();
    check("lock_ready", 64'(seen_ready), 64'h4);
    set_ch(2, 32'h203, 1'b1);
    tick();
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    tick();
    tick();
`endif

    // reset while a beat is held (and, with locking, mid-packet)
    out_ready = 1'b0;
    set_ch(2, 32'hBAD, 1'b0);
    in_valid = 4'b0100;
    tick();
    check("prereset_valid", 64'(out_valid), 64'h1);
    reset = 1'b1;
    set_ch(0, 32'hC0, 1'b1); set_ch(3, 32'h3C3, 1'b1);
    in_valid = 4'b1001;
    tick();
    check("midrst_in_ready",  64'(seen_ready), 64'h0);
    check("midrst_out_valid", 64'(out_valid),  64'h0);
    check("midrst_out_sel",   64'(out_sel),    64'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    push4(2'd0, 32'hC0, 1'b1);
    tick();
    check("postrst_grant", 64'(seen_ready), 64'h1);
    in_valid = '0;
    tick();
    tick();

    check("sb4_drained", 64'(q4.size()), 64'h0);
    check("sb3_drained", 64'(q3.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (>=2).
REQ-003 Localparam SELW = $clog2(N), the width of the channel index.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  N  per-channel beat-valid; bit i belongs to channel i.
REQ-007 in_data  input  N*WIDTH  flat channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_last  input  N  per-channel end-of-packet marker.
REQ-009 in_ready  output  N  per-channel accept; a beat transfers when in_valid[i] && in_ready[i].
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_data  output  WIDTH  registered data of the selected beat.
REQ-012 out_last  output  1  registered last flag of the beat.
REQ-013 out_sel  output  SELW  index of the channel that supplied the beat.
REQ-014 out_ready  input  1  downstream accept; the output transfers when out_valid && out_ready.

Function
REQ-015 Block is a 1-entry output register; can_load = !out_valid || out_ready.
REQ-016 Round-robin pointer ptr (SELW bits): grant goes to the first channel with in_valid set, searching ptr, ptr+1, ... with wrap N-1 -> 0.
REQ-017 in_ready[g] = can_load for the granted channel g; all other in_ready bits are 0; at most one bit is set per cycle.
REQ-018 No in_valid bit set -> no grant, all in_ready 0, ptr unchanged.
REQ-019 On an accepted beat: out_data/out_last/out_sel load the granted channel's data, last flag and index, and out_valid <= 1, in the next cycle (latency 1 cycle).
REQ-020 Output transfers with no new accept -> out_valid <= 0; a simultaneous transfer and accept -> out_valid stays 1 with the new beat (full throughput, 1 beat/cycle).
REQ-021 out_valid && !out_ready -> out_data, out_last and out_sel are held stable and all in_ready are 0.
REQ-022 Pointer update (macro absent): after an accept from channel g, ptr <= g+1, wrapping from N-1 to 0.
REQ-023 Non-power-of-two N: the index arithmetic wraps at N, never at 2**SELW.
REQ-024 A channel that is not granted keeps its data; in_valid withdrawal is not a protocol error for the mux.

Reset
REQ-025 While reset=1 at a clock edge: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, lock cleared.
REQ-026 in_ready is all-zero in any cycle where reset=1.
REQ-027 A reset asserted mid-packet discards the held beat and lock state; the first grant after reset uses ptr=0.

Configuration
REQ-028 Macro RR_STREAM_MUX_LOCK_EN enables packet locking.
REQ-029 With the macro: an accept with in_last=0 from channel g locks the grant to g, ignoring other requests, until a beat with in_last=1 from g is accepted.
REQ-030 With the macro: ptr updates only on acceptance of a last beat; a locked channel that drops in_valid stalls the mux (no other grant).
REQ-031 Without the macro: arbitration is per beat, in_last is passed through only, and no lock state exists.

Structure
REQ-032 Shared package rr_stream_mux_pkg holds the default WIDTH and N constants and a function for the wrap-at-N increment.
REQ-033 Sub-module rr_arbiter (purely combinational; inputs req[N] and ptr; outputs one-hot grant and grant index) is instantiated once.

Verification
REQ-034 N=4, in_valid=4'b1111 held, out_ready=1: out_sel sequence 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after the first accept.
REQ-035 in_valid=4'b1010, ptr=0: grant ch1 (data 0x11); then ch3 (data 0x33); then ch1; out_data sequence 0x11, 0x33, 0x11.
REQ-036 out_ready=0 for 3 cycles with beat 0xDEADBEEF held: out_data constant, in_ready=0; out_ready=1 -> transfer, then the next beat follows.
REQ-037 N=3 with all channels valid: out_sel sequence 0,1,2,0 (wrap at 3, not 4).
REQ-038 LOCK_EN: ch2 sends a 3-beat packet (last on beat 3) while ch0 is also valid: three ch2 beats are output contiguously, then ch0.
REQ-039 reset pulsed while out_valid=1 and locked: next cycle out_valid=0, out_sel=0, in_ready=0; the first grant after reset goes to the lowest valid channel.
